// File: rtl/jtkunio_mainio_if.sv
// CPU-side I/O page bus between the main 6502 decoder and jtkunio_mainio.
// The decoder is the master; the I/O block answers with registered read data.
interface jtkunio_mainio_if;
    logic       cen;
    logic       io_cs;
    logic [2:0] addr;
    logic       cpu_rnw;
    logic [7:0] cpu_dout;
    logic [7:0] io_dout;

    modport master (
        output cen,
        output io_cs,
        output addr,
        output cpu_rnw,
        output cpu_dout,
        input  io_dout
    );

    modport slave (
        input  cen,
        input  io_cs,
        input  addr,
        input  cpu_rnw,
        input  cpu_dout,
        output io_dout
    );
endinterface

// File: rtl/jtkunio_mainio.sv
// Main-CPU I/O page: scroll/flip/bank registers, sound-command FIFO,
// MCU latch handshake and vblank-driven NMI/IRQ with CPU clear strobes.
module jtkunio_mainio #(
    parameter int SCRW   = 10,
    parameter int BANKW  = 1,
    parameter int FIFOAW = 2,
    parameter bit SCR_VB = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    jtkunio_mainio_if.slave      cpu,
    input  logic [1:0]           start,
    input  logic [1:0]           coin,
    input  logic [6:0]           joystick1,
    input  logic [6:0]           joystick2,
    input  logic [7:0]           dipsw_a,
    input  logic [7:0]           dipsw_b,
    input  logic                 vblank,
    output logic [SCRW-1:0]      scrpos,
    output logic                 flip,
    output logic [BANKW-1:0]     bank,
    output logic                 nmin,
    output logic                 irqn,
    output logic [7:0]           snd_latch,
    output logic                 snd_irq,
    input  logic                 snd_ack,
    output logic [7:0]           mcu_latch,
    output logic                 mcu_stb,
    input  logic                 mcu_ack
);

    localparam int              D     = 2**FIFOAW;
    localparam logic [FIFOAW:0] DEPTH = {1'b1, {FIFOAW{1'b0}}};

    logic       we;
    logic       wr_scr_lo, wr_scr_hi, wr_snd, wr_flip, wr_mcu, wr_bank, wr_nmi_clr, wr_irq_clr;
    logic       vb_l, vb_rise, vb_fall;
    logic       nmi_pend, irq_pend;
    logic       snd_ovf;
    logic       fifo_full, fifo_empty;
    logic       do_push, do_pop;
    logic [7:0] mem [D];
    logic [FIFOAW-1:0] wr_ptr, rd_ptr;
    logic [FIFOAW:0]   count;
    logic [7:0] status;
    logic       unused_joy;

    assign unused_joy = ^{joystick1[6], joystick2[6]};

    // write decode
    assign we         = cpu.io_cs & ~cpu.cpu_rnw & cpu.cen;
    assign wr_scr_lo  = we && cpu.addr == 3'd0;
    assign wr_scr_hi  = we && cpu.addr == 3'd1;
    assign wr_snd     = we && cpu.addr == 3'd2;
    assign wr_flip    = we && cpu.addr == 3'd3;
    assign wr_mcu     = we && cpu.addr == 3'd4;
    assign wr_bank    = we && cpu.addr == 3'd5;
    assign wr_nmi_clr = we && cpu.addr == 3'd6;
    assign wr_irq_clr = we && cpu.addr == 3'd7;

    // vblank edge detect
    assign vb_rise = vblank & ~vb_l;
    assign vb_fall = ~vblank & vb_l;

    always_ff @(posedge clk) begin
        if (rst) vb_l <= 1'b0;
        else     vb_l <= vblank;
    end

    // scroll position: shadowed until vblank or written straight through
    generate
        if (SCR_VB) begin : g_scr_shadow
            logic [SCRW-1:0] shadow;
            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow <= '0;
                    scrpos <= '0;
                end else begin
                    if (wr_scr_lo) shadow[7:0]      <= cpu.cpu_dout;
                    if (wr_scr_hi) shadow[SCRW-1:8] <= cpu.cpu_dout[SCRW-9:0];
                    if (vb_rise)   scrpos           <= shadow;
                end
            end
        end else begin : g_scr_direct
            always_ff @(posedge clk) begin
                if (rst) begin
                    scrpos <= '0;
                end else begin
                    if (wr_scr_lo) scrpos[7:0]      <= cpu.cpu_dout;
                    if (wr_scr_hi) scrpos[SCRW-1:8] <= cpu.cpu_dout[SCRW-9:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            flip <= 1'b0;
            bank <= '0;
        end else begin
            if (wr_flip) flip <= ~cpu.cpu_dout[0];
            if (wr_bank) bank <= cpu.cpu_dout[BANKW-1:0];
        end
    end

    // sound FIFO; a full FIFO drops the push even if an ack frees a slot this clk
    assign fifo_full  = (count == DEPTH);
    assign fifo_empty = (count == '0);
    assign do_push    = wr_snd & ~fifo_full;
    assign do_pop     = snd_ack & ~fifo_empty;
    assign snd_latch  = mem[rd_ptr];
    assign snd_irq    = ~fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) mem[i] <= 8'h00;
        end else if (do_push) begin
            mem[wr_ptr] <= cpu.cpu_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            snd_ovf <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (wr_snd && fifo_full) snd_ovf <= 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // MCU latch: a new write always wins over the ack
    always_ff @(posedge clk) begin
        if (rst) begin
            mcu_latch <= 8'h00;
            mcu_stb   <= 1'b0;
        end else if (wr_mcu) begin
            mcu_latch <= cpu.cpu_dout;
            mcu_stb   <= 1'b1;
        end else if (mcu_ack) begin
            mcu_stb   <= 1'b0;
        end
    end

    // interrupt pendings: a vblank edge beats a same-clk CPU clear
    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_pend <= 1'b0;
            irq_pend <= 1'b0;
        end else begin
            if (vb_rise)         nmi_pend <= 1'b1;
            else if (wr_nmi_clr) nmi_pend <= 1'b0;
            if (vb_fall)         irq_pend <= 1'b1;
            else if (wr_irq_clr) irq_pend <= 1'b0;
        end
    end

    assign nmin = ~nmi_pend;
    assign irqn = ~irq_pend;

    assign status = {fifo_full, fifo_empty, snd_ovf, mcu_stb, vblank, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu.io_dout <= 8'hff;
        end else begin
            case (cpu.addr)
                3'd0:    cpu.io_dout <= {start, joystick1[5:0]};
                3'd1:    cpu.io_dout <= {coin, joystick2[5:0]};
                3'd2:    cpu.io_dout <= dipsw_b;
                3'd3:    cpu.io_dout <= dipsw_a;
                3'd4:    cpu.io_dout <= status;
                default: cpu.io_dout <= 8'hff;
            endcase
        end
    end

endmodule
